// File: rtl/vga_pkg.sv
// Shared VGA definitions: 800x600@60 geometry defaults, RGB333 pixel width,
// capture FSM encoding and capture buffer size.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int RGB333_W     = 9;
  localparam int CAP_DATA_W   = 16;
  localparam int CAP_WORDS    = 120000;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_WAIT_FS = 2'd1,
    CAP_CAPTURE = 2'd2
  } cap_state_e;

  // Number of words in a 2:1 x 2:1 decimated frame.
  function automatic int cap_words(input int h_active, input int v_active);
    return (h_active / 2) * (v_active / 2);
  endfunction

endpackage

// File: rtl/vga_capture_if.sv
// VGA stream into the capture block and SRAM write beats out of it.
// CAP_DVLD qualifies CAP_ADDR/CAP_DATA for exactly one cycle per beat; there is
// no ready, so the consumer must take every beat in the cycle it is presented.
interface vga_capture_if
  import vga_pkg::*;
#(
  parameter int PIX_W  = RGB333_W,
  parameter int ADDR_W = 18
);

  logic [PIX_W-1:0]      VGA_DATA;
  logic                  VGA_DE;
  logic                  VGA_HSYNC;
  logic                  VGA_VSYNC;
  logic                  CAP_DVLD;
  logic [ADDR_W-1:0]     CAP_ADDR;
  logic [CAP_DATA_W-1:0] CAP_DATA;

  modport master (
    output VGA_DATA, VGA_DE, VGA_HSYNC, VGA_VSYNC,
    input  CAP_DVLD, CAP_ADDR, CAP_DATA
  );

  modport slave (
    input  VGA_DATA, VGA_DE, VGA_HSYNC, VGA_VSYNC,
    output CAP_DVLD, CAP_ADDR, CAP_DATA
  );

endinterface

// File: rtl/vga_sync_edge.sv
// Registers the VGA sink inputs once and derives frame-start, line-end and
// hsync-fall strobes from the registered values.
module vga_sync_edge
  import vga_pkg::*;
#(
  parameter int PIX_W = RGB333_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] data_i,
  input  logic             de_i,
  input  logic             hs_i,
  input  logic             vs_i,
  output logic [PIX_W-1:0] data_o,
  output logic             de_o,
  output logic             fs_o,
  output logic             le_o,
  output logic             hs_fall_o
);

  logic [PIX_W-1:0] data_q, data_d;
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_prev_q, de_prev_d;
  logic             hs_prev_q, hs_prev_d;
  logic             vs_prev_q, vs_prev_d;

  always_comb begin
    data_d    = data_i;
    de_d      = de_i;
    hs_d      = hs_i;
    vs_d      = vs_i;
    de_prev_d = de_q;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
  end

  // Syncs idle high, so they and their delayed copies reset to 1 to avoid a
  // false edge straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_prev_q <= 1'b0;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      data_q    <= data_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_prev_q <= de_prev_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign data_o    = data_q;
  assign de_o      = de_q;
  assign fs_o      = vs_prev_q & ~vs_q;
  assign le_o      = de_prev_q & ~de_q;
  assign hs_fall_o = hs_prev_q & ~hs_q;

endmodule

// File: rtl/vga_capture.sv
// VGA frame grabber: decimates the active image 2:1 in both axes into
// sequential SRAM write beats and measures/validates the frame geometry.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 18,
  parameter int PIX_W    = RGB333_W
) (
  input  logic          CLK_40M,
  input  logic          SYS_RST,
  input  logic          CAP_EN,
  vga_capture_if.slave  bus,
  output logic          CAP_BUSY,
  output logic          CAP_DONE,
  output logic          CAP_ERR,
  output logic [10:0]   CAP_HMEAS,
  output logic [9:0]    CAP_VMEAS,
  output logic [1:0]    cap_state_dbg
);

  localparam logic [1:0] ST_IDLE    = 2'(CAP_IDLE);
  localparam logic [1:0] ST_WAIT_FS = 2'(CAP_WAIT_FS);
  localparam logic [1:0] ST_CAPTURE = 2'(CAP_CAPTURE);

  localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(cap_words(H_ACTIVE, V_ACTIVE) - 1);

  logic [PIX_W-1:0] pix_s1;
  logic             de_s1;
  logic             fs;
  logic             le;
  logic             hs_fall;

  vga_sync_edge #(.PIX_W(PIX_W)) u_sync (
    .clk       (CLK_40M),
    .rst       (SYS_RST),
    .data_i    (bus.VGA_DATA),
    .de_i      (bus.VGA_DE),
    .hs_i      (bus.VGA_HSYNC),
    .vs_i      (bus.VGA_VSYNC),
    .data_o    (pix_s1),
    .de_o      (de_s1),
    .fs_o      (fs),
    .le_o      (le),
    .hs_fall_o (hs_fall)
  );

  logic [1:0]            state_q, state_d;
  logic [10:0]           x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  en_prev_q, en_prev_d;
  logic                  dvld_q, dvld_d;
  logic [ADDR_W-1:0]     caddr_q, caddr_d;
  logic [CAP_DATA_W-1:0] cdata_q, cdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [10:0]           hmeas_q, hmeas_d;
  logic [9:0]            vmeas_q, vmeas_d;

  logic in_cap;
  logic en_rise;
  logic beat;

  assign in_cap  = (state_q == ST_CAPTURE);
  assign en_rise = CAP_EN & ~en_prev_q;
  // A pixel coinciding with frame start belongs to no frame and is dropped.
  assign beat    = in_cap && de_s1 && !fs && !x_q[0] && !y_q[0] &&
                   (x_q < H_LIM) && (y_q < V_LIM);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    en_prev_d = CAP_EN;
    dvld_d    = 1'b0;
    caddr_d   = caddr_q;
    cdata_d   = cdata_q;
    done_d    = 1'b0;
    err_d     = err_q;
    hmeas_d   = hmeas_q;
    vmeas_d   = vmeas_q;

    if (en_rise) err_d = 1'b0;

    if (de_s1 && (x_q != '1)) x_d = x_q + 11'd1;

    // Sequential address reproduces (y/2)*(H/2)+x/2 for a well-formed frame.
    if (beat) begin
      dvld_d  = 1'b1;
      caddr_d = addr_q;
      cdata_d = {{(CAP_DATA_W - PIX_W){1'b0}}, pix_s1};
      if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
    end

    if (le) begin
      x_d = '0;
      if (y_q != '1) y_d = y_q + 10'd1;
      if (in_cap) begin
        hmeas_d = x_q;
        if (x_q != H_LIM) err_d = 1'b1;
      end
    end

    if (in_cap && hs_fall && de_s1) err_d = 1'b1;

    if (fs) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
      if (in_cap) begin
        done_d  = 1'b1;
        vmeas_d = y_q;
        if ((y_q != V_LIM) || de_s1) err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (CAP_EN) state_d = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (!CAP_EN)  state_d = ST_IDLE;
        else if (fs)  state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (fs && !CAP_EN) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_40M) begin
    if (SYS_RST) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      en_prev_q <= 1'b0;
      dvld_q    <= 1'b0;
      caddr_q   <= '0;
      cdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hmeas_q   <= '0;
      vmeas_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      en_prev_q <= en_prev_d;
      dvld_q    <= dvld_d;
      caddr_q   <= caddr_d;
      cdata_q   <= cdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hmeas_q   <= hmeas_d;
      vmeas_q   <= vmeas_d;
    end
  end

  assign bus.CAP_DVLD  = dvld_q;
  assign bus.CAP_ADDR  = caddr_q;
  assign bus.CAP_DATA  = cdata_q;
  assign CAP_BUSY      = busy_q;
  assign CAP_DONE      = done_q;
  assign CAP_ERR       = err_q;
  assign CAP_HMEAS     = hmeas_q;
  assign CAP_VMEAS     = vmeas_q;
  assign cap_state_dbg = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 16x12 geometry: a frame-level
// model predicts every write beat, plus direct checks of strobes and measurements.
module tb_vga_capture;
  import vga_pkg::*;

  localparam int H      = 16;
  localparam int V      = 12;
  localparam int AW     = 18;
  localparam int PW     = 9;
  localparam int LBLANK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_en = 1'b0;
  logic        busy, done, err;
  logic [10:0] hmeas;
  logic [9:0]  vmeas;
  logic [1:0]  st_dbg;

  vga_capture_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_W(PW)) dut (
    .CLK_40M       (clk),
    .SYS_RST       (rst),
    .CAP_EN        (cap_en),
    .bus           (bus),
    .CAP_BUSY      (busy),
    .CAP_DONE      (done),
    .CAP_ERR       (err),
    .CAP_HMEAS     (hmeas),
    .CAP_VMEAS     (vmeas),
    .cap_state_dbg (st_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] got_q[$];

  task automatic check(input string name, input longint got, input longint req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // driver tasks
  task automatic drive(input logic de, input logic hs, input logic vs, input logic [PW-1:0] d);
    bus.VGA_DE    = de;
    bus.VGA_HSYNC = hs;
    bus.VGA_VSYNC = vs;
    bus.VGA_DATA  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, 1'b1, '0);
  endtask

  function automatic logic [PW-1:0] pix(input int x, input int y);
    return PW'((x + y) & 32'h1FF);
  endfunction

  task automatic send_line(input int y, input int len);
    for (int x = 0; x < len; x++) drive(1'b1, 1'b1, 1'b1, pix(x, y));
    for (int b = 0; b < LBLANK; b++) drive(1'b0, (b == 1 || b == 2) ? 1'b0 : 1'b1, 1'b1, '0);
  endtask

  task automatic send_lines(input int first, input int last, input int norm,
                            input int odd_y, input int odd_len);
    for (int y = first; y <= last; y++) send_line(y, (y == odd_y) ? odd_len : norm);
  endtask

  // Frame start; checks the done strobe two cycles after the vsync fall.
  task automatic send_fs(input bit exp_done, input int exp_v, input int exp_h, input bit exp_err);
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    check("done_pulse", done, exp_done);
    if (exp_done) begin
      check("vmeas", vmeas, exp_v);
      check("hmeas", hmeas, exp_h);
      check("err_at_done", err, exp_err);
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    check("done_one_cycle", done, 0);
    drive(1'b0, 1'b1, 1'b1, '0);
    drive(1'b0, 1'b1, 1'b1, '0);
  endtask

  // Model: beats are the even-x, even-y pixels inside the active window, in
  // raster order, addressed by their ordinal within the frame.
  task automatic model_frame(input int n_lines, input int norm, input int odd_y, input int odd_len);
    int a = 0;
    for (int y = 0; y < n_lines; y++) begin
      int len = (y == odd_y) ? odd_len : norm;
      if ((y % 2) == 0 && y < V) begin
        for (int x = 0; x < len && x < H; x += 2) begin
          exp_q.push_back({AW'(a), 16'(pix(x, y))});
          a++;
        end
      end
    end
  endtask

  task automatic check_frame(input int n_beats);
    check("beat_count", got_q.size(), n_beats);
    check("model_beats_left", exp_q.size(), 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_beat(input string name, input int idx, input int req_addr, input int req_data);
    logic [AW+15:0] b;
    b = (idx < got_q.size()) ? got_q[idx] : '1;
    check({name, "_addr"}, b[AW+15:16], req_addr);
    check({name, "_data"}, b[15:0], req_data);
  endtask

  // scoreboard
  initial begin : scoreboard
    logic [AW+15:0] e;
    forever begin
      @(negedge clk);
      if (bus.CAP_DVLD === 1'b1) begin
        got_q.push_back({bus.CAP_ADDR, bus.CAP_DATA});
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got addr %0d data %0d, required no beat",
                   bus.CAP_ADDR, bus.CAP_DATA);
        end else begin
          e = exp_q.pop_front();
          if (e != {bus.CAP_ADDR, bus.CAP_DATA}) begin
            fails++;
            $display("FAIL beat: got addr %0d data %0d, required addr %0d data %0d",
                     bus.CAP_ADDR, bus.CAP_DATA, e[AW+15:16], e[15:0]);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_dvld"}, bus.CAP_DVLD, 0);
    check({tag, "_addr"}, bus.CAP_ADDR, 0);
    check({tag, "_data"}, bus.CAP_DATA, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_hmeas"}, hmeas, 0);
    check({tag, "_vmeas"}, vmeas, 0);
  endtask

  initial begin
    bus.VGA_DE    = 1'b0;
    bus.VGA_HSYNC = 1'b1;
    bus.VGA_VSYNC = 1'b1;
    bus.VGA_DATA  = '0;
    idle(2);
    check_all_zero("reset");
    check("reset_state", st_dbg, 0);
    rst = 1'b0;
    idle(2);

    cap_en = 1'b1;
    idle(1);
    check("busy_rise", busy, 1);
    idle(3);
    send_fs(1'b0, 0, 0, 1'b0);

    // Clean frame.
    model_frame(V, H, -1, 0);
    send_lines(0, V - 1, H, -1, 0);
    send_fs(1'b1, V, H, 1'b0);
    check_beat("first_beat", 0, 0, 0);
    check_beat("beat8", 8, 8, 2);
    check_beat("last_beat", 47, 47, 24);
    check_frame(48);

    // Line 10 two pixels short.
    model_frame(V, H, 10, H - 2);
    send_lines(0, 9, H, -1, 0);
    check("err_before_short", err, 0);
    send_line(10, H - 2);
    check("err_after_short", err, 1);
    send_lines(11, V - 1, H, -1, 0);
    send_fs(1'b1, V, H, 1'b1);
    check_frame(47);

    // Clean frame: error stays sticky.
    model_frame(V, H, -1, 0);
    send_lines(0, V - 1, H, -1, 0);
    send_fs(1'b1, V, H, 1'b1);
    check_frame(48);

    cap_en = 1'b0;
    idle(1);
    cap_en = 1'b1;
    idle(1);
    check("err_clear_on_en", err, 0);
    check("busy_after_toggle", busy, 1);

    // CAP_EN dropped at line 6: frame still completes.
    model_frame(V, H, -1, 0);
    send_lines(0, 5, H, -1, 0);
    cap_en = 1'b0;
    send_lines(6, V - 1, H, -1, 0);
    send_fs(1'b1, V, H, 1'b0);
    check("busy_after_drop", busy, 0);
    check_frame(48);

    // Idle frame, CAP_EN raised mid-frame: nothing until next FS.
    send_lines(0, 3, H, -1, 0);
    cap_en = 1'b1;
    send_lines(4, V - 1, H, -1, 0);
    check("busy_wait_fs", busy, 1);
    send_fs(1'b0, 0, 0, 1'b0);
    check_frame(0);

    model_frame(V, H, -1, 0);
    send_lines(0, V - 1, H, -1, 0);
    send_fs(1'b1, V, H, 1'b0);
    check_beat("armed_first", 0, 0, 0);
    check_frame(48);

    // Reset pulse at line 6 with CAP_EN held.
    model_frame(6, H, -1, 0);
    send_lines(0, 5, H, -1, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_all_zero("midreset");
    check_frame(24);
    send_lines(6, V - 1, H, -1, 0);
    send_fs(1'b0, 0, 0, 1'b0);
    check_frame(0);

    model_frame(V, H, -1, 0);
    send_lines(0, V - 1, H, -1, 0);
    send_fs(1'b1, V, H, 1'b0);
    check_beat("post_reset_first", 0, 0, 0);
    check_frame(48);

    // Oversize frame: 14 lines of 18 pixels.
    model_frame(V + 2, H + 2, -1, 0);
    send_lines(0, V + 1, H + 2, -1, 0);
    send_fs(1'b1, V + 2, H + 2, 1'b1);
    check_beat("oversize_last", 47, 47, 24);
    check_frame(48);

    cap_en = 1'b0;
    idle(5);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Frame-capture block in the CLK_40M domain, the receiving end of the VGA output interface. It decodes a VGA_DATA/VGA_DE/VGA_HSYNC/VGA_VSYNC stream, decimates the 800x600 active image 2:1 in each axis to 400x300, and emits SRAM write beats (address/data/valid) in the same form as the SLCT_IN_* write path. Uses: loopback verification of VGA_CTRL, and frame grab into SRAM for UART readback. It also measures the incoming frame geometry and flags malformed frames.

## Interface
Parameters:
- H_ACTIVE, 800, active pixels per line (even)
- V_ACTIVE, 600, active lines per frame (even)
- ADDR_W, 18, SRAM word address width
- PIX_W, 9, VGA pixel width (RGB333)

Ports:
- CLK_40M  in  1  pixel clock; the only clock
- SYS_RST  in  1  synchronous, active-high reset
- CAP_EN  in  1  level; arm continuous capture
- VGA_DATA  in  PIX_W  pixel, valid when VGA_DE=1
- VGA_DE  in  1  active-video enable
- VGA_HSYNC  in  1  line sync, active-low
- VGA_VSYNC  in  1  frame sync, active-low
- CAP_DVLD  out  1  write beat valid, one cycle per beat
- CAP_ADDR  out  ADDR_W  SRAM word address
- CAP_DATA  out  16  {7'b0, pixel}
- CAP_BUSY  out  1  state is not IDLE
- CAP_DONE  out  1  one-cycle pulse on each completed frame
- CAP_ERR  out  1  sticky geometry error
- CAP_HMEAS  out  11  DE-high count of the last completed line
- CAP_VMEAS  out  10  line count of the last completed frame

## Operation
- All VGA_* inputs are registered once (stage S1). All decode works on S1 values.
- Frame start (FS) = S1 VSYNC 1->0 edge. Line end (LE) = S1 DE 1->0 edge.
- Counters:
  - x: 11 bits; counts DE-high cycles; cleared at LE and FS.
  - y: 10 bits; incremented at LE; cleared at FS.
  - addr: ADDR_W bits; cleared at FS.
- Beat condition: DE=1, x[0]=0, y[0]=0, x<H_ACTIVE, y<V_ACTIVE.
  - On a beat, CAP_ADDR = addr, then addr increments.
  - Address equals (y/2)*(H_ACTIVE/2)+x/2. No multiplier is allowed.
  - Last address is 119999; addr never wraps.
- Pixels with x>=H_ACTIVE and lines with y>=V_ACTIVE are discarded and produce no beat.
- FSM states: IDLE, WAIT_FS, CAPTURE.
  - IDLE -> WAIT_FS when CAP_EN=1.
  - WAIT_FS -> CAPTURE on FS. In WAIT_FS: no beats, no errors.
  - CAPTURE on FS: pulse CAP_DONE and latch CAP_VMEAS=y. Then:
    - if CAP_EN=1, stay in CAPTURE (the next frame starts in the same cycle);
    - otherwise go to IDLE.
  - CAP_EN dropping mid-frame does not abort: the current frame completes, then the FSM goes to IDLE. In IDLE, CAP_EN=0 and WAIT_FS returns to IDLE.
- CAP_HMEAS = x, latched at every LE in CAPTURE.
- CAP_ERR is set in CAPTURE on any of:
  - LE with x != H_ACTIVE;
  - FS with y != V_ACTIVE;
  - S1 DE=1 in the same cycle as FS (that pixel is discarded).
  - CAP_ERR is cleared only on a CAP_EN 0->1 edge or on reset.
- HSYNC is used only for the consistency check: an HSYNC low pulse while DE=1 sets CAP_ERR.

## Timing
- Reset (synchronous, SYS_RST=1 at an edge): state=IDLE. All outputs, counters and S1 registers become 0, except S1 VSYNC/HSYNC, which reset to 1 (sync idle-high).
- Latency: a pixel on VGA_* at edge N gives CAP_DVLD/CAP_ADDR/CAP_DATA at edge N+2 (S1 register plus output register).
- CAP_DVLD is high for exactly one cycle per beat. No back-pressure: the consumer must accept a beat every cycle. Beats are at most one per 2 cycles within a line.
- CAP_DONE is asserted 2 cycles after the VSYNC falling edge on the pins. CAP_HMEAS, CAP_VMEAS and CAP_ERR update in that same cycle.
- CAP_BUSY is registered. It goes high 1 cycle after CAP_EN rises in IDLE.
- Reset mid-frame: no further beats. After release, capture resumes only on the next FS after CAP_EN=1.

## Structure
- Shared package vga_pkg: H_ACTIVE/V_ACTIVE defaults for 800x600@60, the RGB333 width, the capture state enum, and CAP_WORDS = 120000.
- One sub-module: vga_sync_edge. It provides input registering and edge detection, outputs FS/LE/HSYNC-pulse strobes, and is reusable by other sinks.
- Counters and FSM stay in vga_capture.

## Test plan
- CAP_EN=1, clean 800x600 frame, pixel = (x+y)&0x1FF:
  - exactly 120000 beats;
  - first beat addr 0, data 0; beat 400 has addr 400 and data 2 (x=0, y=2);
  - last beat addr 119999;
  - CAP_DONE once, CAP_ERR=0, CAP_HMEAS=800, CAP_VMEAS=600.
- Line 10 carries 798 DE cycles: CAP_ERR=1 at that LE; beat count for the frame = 119999. CAP_ERR stays 1 through the next clean frame and clears on a CAP_EN 0->1 toggle.
- CAP_EN asserted mid-frame: no beats until the next FS; then a full frame starting at addr 0.
- CAP_EN dropped at line 300: the frame completes (120000 beats), CAP_DONE pulses, then BUSY=0 and there are no beats on the following frame.
- SYS_RST asserted for 1 cycle at line 200 with CAP_EN held at 1:
  - every output is 0 the cycle after the reset edge;
  - the next beat is at addr 0 after the next FS.
- Frame with 602 lines and 802-pixel lines: beats still stop at addr 119999, CAP_ERR=1, CAP_VMEAS=602, CAP_HMEAS=802.
